cb_wr_align: RTL and testbench
==============================

CB_WR_ALIGN -- requirements
Module: CB_wr_align

Interface
REQ-001 SHALL have parameter L, default 4, meaning number of PE lanes and write-back lanes.
REQ-002 SHALL have parameter CB_AW, default 19, meaning CB address width.
REQ-003 SHALL have parameter CB_DW, default 64, meaning data width per lane.
REQ-004 SHALL have parameter ROW_LEN, default 10, meaning burst length counter width.
REQ-005 SHALL have port clk  input  1  single clock; all logic is on the rising edge.
REQ-006 SHALL have port sys_rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port start  input  1  single-cycle burst start pulse.
REQ-008 SHALL have port len  input  ROW_LEN  number of aligned words in the burst, sampled on start.
REQ-009 SHALL have port base_addr  input  CB_AW  first write address, sampled on start.
REQ-010 SHALL have port din_valid  input  L  per-lane result valid; lane i is skewed i cycles after lane 0.
REQ-011 SHALL have port din  input  CB_DW*L  per-lane result data; lane i occupies bits [CB_DW*(i+1)-1 : CB_DW*i].
REQ-012 SHALL have port CB_enb  output  1  CB port-B enable.
REQ-013 SHALL have port CB_web  output  L  CB port-B per-lane write enable.
REQ-014 SHALL have port CB_addrb  output  CB_AW  CB port-B write address.
REQ-015 SHALL have port CB_dinb  output  CB_DW*L  aligned write data.
REQ-016 SHALL have port busy  output  1  high from the accepted start until done.
REQ-017 SHALL have port done  output  1  single-cycle pulse at the end of the burst.
REQ-018 SHALL have port skew_err  output  1  sticky flag for lane misalignment or data outside a burst.

Function
REQ-019 SHALL delay lane i valid and data by L-1-i cycles, then register the result once, so that lane-0 data presented at cycle t and lane-i data presented at cycle t+i appear together on the outputs at cycle t+L.
REQ-020 SHALL implement FSM states IDLE, RUN and DONE.
REQ-021 SHALL, in IDLE with start=1, capture len and base_addr, clear the word counter k, and go to RUN; if captured len=0 it SHALL go to DONE instead.
REQ-022 SHALL ignore start in RUN and DONE.
REQ-023 SHALL write an aligned word in RUN when aligned lane-0 valid=1, driving: CB_enb=1; CB_web = aligned valid vector; CB_addrb = base_addr + k (modulo 2^CB_AW, wraps); CB_dinb = aligned data; then k increments.
REQ-024 SHALL go from RUN to DONE in the cycle after the write with k = len-1.
REQ-025 SHALL drive done=1 for exactly one cycle while in DONE, then return to IDLE.
REQ-026 SHALL drive busy=1 in RUN and DONE, and busy=0 in IDLE.
REQ-027 SHALL drive CB_enb=0, CB_web=0, CB_addrb=0 and CB_dinb=0 in every cycle with no write.
REQ-028 SHALL set skew_err when an aligned lane i>0 valid=1 while aligned lane-0 valid=0, or when aligned lane-0 valid=1 outside RUN; that word SHALL NOT be written.
REQ-029 SHALL clear skew_err only on reset or on an accepted start.
REQ-030 SHALL allow a partial write when aligned lane-0 valid=1 and some lanes i>0 are 0: the write proceeds with only those CB_web bits clear, and skew_err is NOT set.
REQ-031 SHALL keep lane 0's delay line at L-1 stages even when only lane 0 is in use.

Reset
REQ-032 SHALL, when sys_rst=1 at a clock edge, clear all delay stages, the FSM (to IDLE), k, busy, done, skew_err and all CB_* outputs to 0, including mid-burst.
REQ-033 SHALL NOT write in the first L cycles after reset release, because the delay lines hold zeros.

Verification
REQ-034 Scenario: L=4, start with len=3 and base_addr=100; all lanes valid, skewed, for 3 words starting t=2 -> CB_enb=1 at t=6,7,8; CB_addrb=100,101,102; CB_web=4'hF; done at t=9.
REQ-035 Scenario: start with len=0 -> no write occurs; busy=1 for 1 cycle; done on the cycle after start.
REQ-036 Scenario: base_addr=2^19-1 with len=2 -> CB_addrb=524287 and then 0.
REQ-037 Scenario: lane-2 valid asserted one cycle late -> skew_err=1; the word for that slot is not written; skew_err holds until the next start.
REQ-038 Scenario: sys_rst pulsed mid-burst after 1 of 4 words -> all outputs are 0 the next cycle; no done pulse occurs; a new start with len=1 completes normally.
REQ-039 Scenario: start re-pulsed during RUN -> it is ignored; addresses continue from the original base_addr.

Source files
------------

// File: rtl/cb_wr_align.sv
// De-skews L staggered PE result lanes into aligned words and writes them as
// a burst of consecutive addresses on the CB port B.
module cb_wr_align #(
    parameter int L       = 4,
    parameter int CB_AW   = 19,
    parameter int CB_DW   = 64,
    parameter int ROW_LEN = 10
) (
    input  logic                 clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic [ROW_LEN-1:0]   len,
    input  logic [CB_AW-1:0]     base_addr,
    input  logic [L-1:0]         din_valid,
    input  logic [CB_DW*L-1:0]   din,
    output logic                 CB_enb,
    output logic [L-1:0]         CB_web,
    output logic [CB_AW-1:0]     CB_addrb,
    output logic [CB_DW*L-1:0]   CB_dinb,
    output logic                 busy,
    output logic                 done,
    output logic                 skew_err
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    logic [L-1:0]       a_valid;
    logic [CB_DW*L-1:0] a_data;

    // Lane i sits behind L-1-i stages so every lane lines up with lane 0.
    for (genvar i = 0; i < L - 1; i++) begin : g_lane
        localparam int D = L - 1 - i;
        logic [CB_DW:0] dl_q [D];
        logic [CB_DW:0] dl_d [D];

        always_comb begin
            dl_d[0] = {din_valid[i], din[CB_DW*i +: CB_DW]};
            for (int j = 1; j < D; j++) begin
                dl_d[j] = dl_q[j-1];
            end
        end

        always_ff @(posedge clk) begin
            if (sys_rst) begin
                for (int j = 0; j < D; j++) begin
                    dl_q[j] <= '0;
                end
            end else begin
                for (int j = 0; j < D; j++) begin
                    dl_q[j] <= dl_d[j];
                end
            end
        end

        assign a_valid[i]                = dl_q[D-1][CB_DW];
        assign a_data[CB_DW*i +: CB_DW]  = dl_q[D-1][CB_DW-1:0];
    end

    assign a_valid[L-1]                  = din_valid[L-1];
    assign a_data[CB_DW*(L-1) +: CB_DW]  = din[CB_DW*(L-1) +: CB_DW];

    state_t             state_q, state_d;
    logic [ROW_LEN-1:0] len_q, len_d;
    logic [CB_AW-1:0]   base_q, base_d;
    logic [ROW_LEN-1:0] k_q, k_d;
    logic               last_q, last_d;
    logic               enb_q, enb_d;
    logic [L-1:0]       web_q, web_d;
    logic [CB_AW-1:0]   addr_q, addr_d;
    logic [CB_DW*L-1:0] dinb_q, dinb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               accept;
    logic               wr;

    // last_q marks that the final word has been issued; the burst retires the cycle after it.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        base_d  = base_q;
        k_d     = k_q;
        last_d  = 1'b0;
        accept  = (state_q == S_IDLE) && start;
        wr      = (state_q == S_RUN) && !last_q && a_valid[0];
        enb_d   = wr;
        web_d   = wr ? a_valid : '0;
        addr_d  = wr ? base_q + CB_AW'(k_q) : '0;
        dinb_d  = wr ? a_data : '0;
        err_d   = (accept ? 1'b0 : err_q)
                | ((|a_valid[L-1:1]) && !a_valid[0])
                | (a_valid[0] && !wr);
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    base_d  = base_addr;
                    k_d     = '0;
                    state_d = (len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (last_q) begin
                    state_d = S_DONE;
                end else if (wr) begin
                    k_d    = k_q + ROW_LEN'(1);
                    last_d = (k_q == len_q - ROW_LEN'(1));
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            base_q  <= '0;
            k_q     <= '0;
            last_q  <= 1'b0;
            enb_q   <= 1'b0;
            web_q   <= '0;
            addr_q  <= '0;
            dinb_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            base_q  <= base_d;
            k_q     <= k_d;
            last_q  <= last_d;
            enb_q   <= enb_d;
            web_q   <= web_d;
            addr_q  <= addr_d;
            dinb_q  <= dinb_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign CB_enb   = enb_q;
    assign CB_web   = web_q;
    assign CB_addrb = addr_q;
    assign CB_dinb  = dinb_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign skew_err = err_q;

endmodule

// File: tb/tb_cb_wr_align.sv
// Randomised bench for cb_wr_align: per-cycle stimulus tables replayed into the
// DUT and compared against a lane-indexing model of the aligned write stream.
module tb_cb_wr_align;

    localparam int L  = 4;
    localparam int AW = 19;
    localparam int DW = 64;
    localparam int RL = 10;
    localparam int NC = 48;
    localparam int T0 = 4;

    typedef struct packed {
        logic          enb;
        logic [L-1:0]  web;
        logic [AW-1:0] addr;
        logic [L*DW-1:0] dinb;
        logic          busy;
        logic          done;
        logic          err;
    } out_t;

    logic            clk = 1'b0;
    logic            sys_rst = 1'b0;
    logic            start = 1'b0;
    logic [RL-1:0]   len = '0;
    logic [AW-1:0]   base_addr = '0;
    logic [L-1:0]    din_valid = '0;
    logic [L*DW-1:0] din = '0;
    logic            CB_enb;
    logic [L-1:0]    CB_web;
    logic [AW-1:0]   CB_addrb;
    logic [L*DW-1:0] CB_dinb;
    logic            busy;
    logic            done;
    logic            skew_err;

    logic [L-1:0]    raw_v   [NC+8];
    logic [L*DW-1:0] raw_d   [NC+8];
    logic            st_rst  [NC+8];
    logic            st_start[NC+8];
    logic [RL-1:0]   st_len  [NC+8];
    logic [AW-1:0]   st_base [NC+8];
    out_t            exp_o   [NC+2];
    out_t            obs_o   [NC+2];

    int total = 0;
    int bad   = 0;

    cb_wr_align #(.L(L), .CB_AW(AW), .CB_DW(DW), .ROW_LEN(RL)) dut (
        .clk(clk), .sys_rst(sys_rst), .start(start), .len(len), .base_addr(base_addr),
        .din_valid(din_valid), .din(din), .CB_enb(CB_enb), .CB_web(CB_web),
        .CB_addrb(CB_addrb), .CB_dinb(CB_dinb), .busy(busy), .done(done), .skew_err(skew_err)
    );

    always #5 clk = ~clk;

    task automatic clear_stim();
        for (int c = 0; c < NC + 8; c++) begin
            raw_v[c]    = '0;
            for (int i = 0; i < L; i++) raw_d[c][i*DW +: DW] = {$urandom, $urandom};
            st_rst[c]   = 1'b0;
            st_start[c] = 1'b0;
            st_len[c]   = '0;
            st_base[c]  = '0;
        end
        st_rst[0] = 1'b1;
        st_rst[1] = 1'b1;
    endtask

    task automatic put_lane(input int p, input int i);
        raw_v[p][i] = 1'b1;
        raw_d[p][i*DW +: DW] = {$urandom, $urandom};
    endtask

    // A word whose lane 0 is presented at cycle c has lane i presented at c+i.
    task automatic put_slot(input int c, input logic [L-1:0] v);
        for (int i = 0; i < L; i++) if (v[i]) put_lane(c + i, i);
    endtask

    task automatic put_start(input int c, input int n, input int b);
        st_start[c] = 1'b1;
        st_len[c]   = RL'(n);
        st_base[c]  = AW'(b);
    endtask

    task automatic run_scenario();
        for (int c = 0; c < NC; c++) begin
            @(negedge clk);
            sys_rst   = st_rst[c];
            start     = st_start[c];
            len       = st_len[c];
            base_addr = st_base[c];
            din_valid = raw_v[c];
            din       = raw_d[c];
            @(posedge clk);
            #1;
            obs_o[c+1] = {CB_enb, CB_web, CB_addrb, CB_dinb, busy, done, skew_err};
        end
        @(negedge clk);
        start     = 1'b0;
        din_valid = '0;
    endtask

    // Reference: the aligned word seen at decision cycle d takes lane i from
    // cycle d-(L-1)+i, unless a reset came at or after that presentation.
    task automatic build_expected();
        int            rst_last;
        bit            active;
        bit            burst_open;
        int            remaining;
        int            busy_until;
        logic [AW-1:0] nxt;
        logic          err;
        logic [L-1:0]  av;
        logic [L*DW-1:0] ad;
        bit            accept;
        bit            wr;
        rst_last = -1; active = 0; burst_open = 0; remaining = 0;
        busy_until = -1; nxt = '0; err = 1'b0;
        for (int c = 0; c < NC + 2; c++) exp_o[c] = '0;
        for (int d = 0; d < NC; d++) begin
            if (st_rst[d]) begin
                rst_last = d; active = 0; burst_open = 0; remaining = 0;
                busy_until = -1; err = 1'b0;
                exp_o[d+1] = '0;
                continue;
            end
            av = '0;
            ad = '0;
            for (int i = 0; i < L; i++) begin
                int p;
                p = d - (L - 1) + i;
                if (p >= 0 && p > rst_last) begin
                    av[i] = raw_v[p][i];
                    ad[i*DW +: DW] = raw_d[p][i*DW +: DW];
                end
            end
            accept = st_start[d] && !exp_o[d].busy;
            wr = 0;
            if (accept) begin
                err = 1'b0;
                if (st_len[d] == 0) begin
                    busy_until = d + 1;
                    exp_o[d+1].done = 1'b1;
                end else begin
                    active = 1; burst_open = 1;
                    remaining = int'(st_len[d]);
                    nxt = st_base[d];
                end
            end else if (active && av[0]) begin
                wr = 1;
                exp_o[d+1].enb  = 1'b1;
                exp_o[d+1].web  = av;
                exp_o[d+1].addr = nxt;
                exp_o[d+1].dinb = ad;
                nxt = nxt + 1'b1;
                remaining--;
                if (remaining == 0) begin
                    active = 0; burst_open = 0;
                    busy_until = d + 2;
                    exp_o[d+2].done = 1'b1;
                end
            end
            if (((|av[L-1:1]) && !av[0]) || (av[0] && !wr)) err = 1'b1;
            exp_o[d+1].err  = err;
            exp_o[d+1].busy = burst_open || (d + 1 <= busy_until);
        end
    endtask

    task automatic test_reset();
        int n_enb;
        clear_stim();
        for (int c = 0; c < 2; c++) put_slot(c, '1);
        for (int c = 0; c < 2; c++) raw_v[c] = '1;
        put_start(2, 4, 5);
        run_scenario();
        build_expected();
        for (int c = 1; c <= NC; c++) begin
            total++;
            if (obs_o[c] !== exp_o[c]) begin
                bad++;
                $display("[TB] FAIL reset_cyc%0d got=%h want=%h", c, obs_o[c], exp_o[c]);
            end
        end
        total++;
        if (obs_o[1] !== out_t'(0)) begin
            bad++;
            $display("[TB] FAIL reset_zero got=%h want=0", obs_o[1]);
        end
        n_enb = 0;
        for (int c = 1; c <= NC; c++) n_enb += int'(obs_o[c].enb);
        total++;
        if (n_enb !== 0) begin
            bad++;
            $display("[TB] FAIL reset_stale_write got=%0d want=0", n_enb);
        end
    endtask

    task automatic test_basic();
        clear_stim();
        put_start(T0, 3, 100);
        for (int s = 0; s < 3; s++) put_slot(T0 + 2 + s, '1);
        run_scenario();
        build_expected();
        for (int c = 1; c <= NC; c++) begin
            total++;
            if (obs_o[c] !== exp_o[c]) begin
                bad++;
                $display("[TB] FAIL basic_cyc%0d got=%h want=%h", c, obs_o[c], exp_o[c]);
            end
        end
        total++;
        if (obs_o[T0+5].enb !== 1'b0) begin
            bad++;
            $display("[TB] FAIL basic_early got=%b want=0", obs_o[T0+5].enb);
        end
        for (int j = 0; j < 3; j++) begin
            total++;
            if ({obs_o[T0+6+j].enb, obs_o[T0+6+j].web, obs_o[T0+6+j].addr} !== {1'b1, 4'hF, AW'(100 + j)}) begin
                bad++;
                $display("[TB] FAIL basic_word%0d got=%b/%h/%0d want=1/f/%0d", j,
                         obs_o[T0+6+j].enb, obs_o[T0+6+j].web, obs_o[T0+6+j].addr, 100 + j);
            end
        end
        total++;
        if ({obs_o[T0+8].done, obs_o[T0+9].done, obs_o[T0+10].busy} !== 3'b010) begin
            bad++;
            $display("[TB] FAIL basic_done got=%b want=010",
                     {obs_o[T0+8].done, obs_o[T0+9].done, obs_o[T0+10].busy});
        end
    endtask

    task automatic test_len_zero();
        int n_enb;
        clear_stim();
        put_start(T0, 0, 77);
        run_scenario();
        build_expected();
        for (int c = 1; c <= NC; c++) begin
            total++;
            if (obs_o[c] !== exp_o[c]) begin
                bad++;
                $display("[TB] FAIL len0_cyc%0d got=%h want=%h", c, obs_o[c], exp_o[c]);
            end
        end
        total++;
        if ({obs_o[T0].busy, obs_o[T0+1].busy, obs_o[T0+1].done, obs_o[T0+2].busy, obs_o[T0+2].done} !== 5'b01100) begin
            bad++;
            $display("[TB] FAIL len0_pulse got=%b want=01100",
                     {obs_o[T0].busy, obs_o[T0+1].busy, obs_o[T0+1].done, obs_o[T0+2].busy, obs_o[T0+2].done});
        end
        n_enb = 0;
        for (int c = 1; c <= NC; c++) n_enb += int'(obs_o[c].enb);
        total++;
        if (n_enb !== 0) begin
            bad++;
            $display("[TB] FAIL len0_write got=%0d want=0", n_enb);
        end
    endtask

    task automatic test_wrap();
        clear_stim();
        put_start(T0, 2, 524287);
        put_slot(T0 + 2, '1);
        put_slot(T0 + 3, '1);
        run_scenario();
        build_expected();
        for (int c = 1; c <= NC; c++) begin
            total++;
            if (obs_o[c] !== exp_o[c]) begin
                bad++;
                $display("[TB] FAIL wrap_cyc%0d got=%h want=%h", c, obs_o[c], exp_o[c]);
            end
        end
        total++;
        if ({obs_o[T0+6].enb, obs_o[T0+6].addr, obs_o[T0+7].enb, obs_o[T0+7].addr} !== {1'b1, 19'd524287, 1'b1, 19'd0}) begin
            bad++;
            $display("[TB] FAIL wrap_addr got=%0d,%0d want=524287,0", obs_o[T0+6].addr, obs_o[T0+7].addr);
        end
    endtask

    task automatic test_skew();
        int n_enb;
        clear_stim();
        put_start(T0, 3, 50);
        put_slot(T0 + 2, '1);
        put_slot(T0 + 3, '1);
        put_slot(T0 + 4, 4'b1011);
        put_lane(T0 + 4 + 2 + 1, 2);
        put_start(T0 + 12, 1, 60);
        put_slot(T0 + 14, '1);
        run_scenario();
        build_expected();
        for (int c = 1; c <= NC; c++) begin
            total++;
            if (obs_o[c] !== exp_o[c]) begin
                bad++;
                $display("[TB] FAIL skew_cyc%0d got=%h want=%h", c, obs_o[c], exp_o[c]);
            end
        end
        total++;
        if ({obs_o[T0+8].enb, obs_o[T0+8].web, obs_o[T0+8].err} !== {1'b1, 4'b1011, 1'b0}) begin
            bad++;
            $display("[TB] FAIL skew_partial got=%b/%b/%b want=1/1011/0",
                     obs_o[T0+8].enb, obs_o[T0+8].web, obs_o[T0+8].err);
        end
        total++;
        if ({obs_o[T0+9].err, obs_o[T0+12].err, obs_o[T0+13].err} !== 3'b110) begin
            bad++;
            $display("[TB] FAIL skew_sticky got=%b want=110",
                     {obs_o[T0+9].err, obs_o[T0+12].err, obs_o[T0+13].err});
        end
        n_enb = 0;
        for (int c = T0 + 9; c <= T0 + 17; c++) n_enb += int'(obs_o[c].enb);
        total++;
        if (n_enb !== 0) begin
            bad++;
            $display("[TB] FAIL skew_stray_write got=%0d want=0", n_enb);
        end
    endtask

    task automatic test_mid_reset();
        int n_done;
        clear_stim();
        put_start(T0, 4, 10);
        for (int s = 0; s < 4; s++) put_slot(T0 + 2 + s, '1);
        st_rst[T0+6] = 1'b1;
        put_start(T0 + 8, 1, 33);
        put_slot(T0 + 10, '1);
        run_scenario();
        build_expected();
        for (int c = 1; c <= NC; c++) begin
            total++;
            if (obs_o[c] !== exp_o[c]) begin
                bad++;
                $display("[TB] FAIL midrst_cyc%0d got=%h want=%h", c, obs_o[c], exp_o[c]);
            end
        end
        total++;
        if (obs_o[T0+7] !== out_t'(0)) begin
            bad++;
            $display("[TB] FAIL midrst_clear got=%h want=0", obs_o[T0+7]);
        end
        n_done = 0;
        for (int c = T0 + 7; c <= T0 + 14; c++) n_done += int'(obs_o[c].done);
        total++;
        if (n_done !== 0) begin
            bad++;
            $display("[TB] FAIL midrst_nodone got=%0d want=0", n_done);
        end
        total++;
        if ({obs_o[T0+14].enb, obs_o[T0+14].addr, obs_o[T0+15].done} !== {1'b1, AW'(33), 1'b1}) begin
            bad++;
            $display("[TB] FAIL midrst_rerun got=%b/%0d/%b want=1/33/1",
                     obs_o[T0+14].enb, obs_o[T0+14].addr, obs_o[T0+15].done);
        end
    endtask

    task automatic test_restart_ignored();
        clear_stim();
        put_start(T0, 3, 200);
        put_start(T0 + 3, 7, 900);
        for (int s = 0; s < 3; s++) put_slot(T0 + 2 + s, '1);
        run_scenario();
        build_expected();
        for (int c = 1; c <= NC; c++) begin
            total++;
            if (obs_o[c] !== exp_o[c]) begin
                bad++;
                $display("[TB] FAIL restart_cyc%0d got=%h want=%h", c, obs_o[c], exp_o[c]);
            end
        end
        for (int j = 0; j < 3; j++) begin
            total++;
            if (obs_o[T0+6+j].addr !== AW'(200 + j)) begin
                bad++;
                $display("[TB] FAIL restart_addr%0d got=%0d want=%0d", j, obs_o[T0+6+j].addr, 200 + j);
            end
        end
        total++;
        if (obs_o[T0+9].done !== 1'b1) begin
            bad++;
            $display("[TB] FAIL restart_done got=%b want=1", obs_o[T0+9].done);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            int n;
            int c;
            logic [L-1:0] v;
            clear_stim();
            n = int'($urandom_range(1, 6));
            put_start(3, n, int'($urandom_range(0, (1 << AW) - 1)));
            if ($urandom_range(0, 1) == 1) put_start(6, int'($urandom_range(0, 9)), 1234);
            c = 5;
            for (int s = 0; s < n + 1; s++) begin
                v = L'($urandom);
                if ($urandom_range(0, 4) != 0) v[0] = 1'b1;
                put_slot(c, v);
                c = c + 1 + int'($urandom_range(0, 2));
            end
            run_scenario();
            build_expected();
            for (int k = 1; k <= NC; k++) begin
                total++;
                if (obs_o[k] !== exp_o[k]) begin
                    bad++;
                    $display("[TB] FAIL rand%0d_cyc%0d got=%h want=%h", it, k, obs_o[k], exp_o[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_zero();
        test_wrap();
        test_skew();
        test_mid_reset();
        test_restart_ignored();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
